seq_div_unit: RTL

Parametrised multi-cycle integer divider. Replaces the single-shot DIV path that feeds the Z register for the HI/LO writeback.
Restoring radix-2 algorithm with a start/done handshake and selectable signed or unsigned mode.
Produces the quotient (written to LO) and the remainder (written to HI) in one registered result.
Sits between the Y/bus operand sources and the Z/HI/LO registers, and is driven by the control-unit sequencer.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 31 +++
 rtl/seq_div_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// default operand width and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    // Quotient reported on divide by zero: all ones at any width.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quo} left, trial-subtract
// the divisor magnitude, keep the difference and set the quotient LSB when
// the trial result is non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvs_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH-1:0] shifted_lo;
    logic             shifted_hi;
    logic [WIDTH:0]   trial;
    logic             take;

    // The shifted remainder is WIDTH+1 bits. When its top bit is set it is
    // at least 2^WIDTH and always exceeds the divisor, so the low WIDTH bits
    // of the difference are exact; otherwise the borrow decides.
    always_comb begin
        shifted_hi = rem_in[WIDTH-1];
        shifted_lo = {rem_in[WIDTH-2:0], quo_in[WIDTH-1]};
        trial      = {1'b0, shifted_lo} - {1'b0, dvs_in};
        take       = shifted_hi | ~trial[WIDTH];
        rem_out    = take ? trial[WIDTH-1:0] : shifted_lo;
        quo_out    = {quo_in[WIDTH-2:0], take};
    end

endmodule

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring integer divider with start/done handshake and
// signed/unsigned mode. Quotient goes to LO, remainder to HI.
// Optional macro SEQ_DIV_EARLY_TERM_EN: when |divisor| > |dividend| the
// iterations are skipped (results unchanged, done two cycles after start).
module seq_div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic             early_q, early_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] rem_step, quo_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvs_in  (dvs_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    // Operand magnitudes; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude.
    always_comb begin
        dvd_neg = is_signed & dividend[WIDTH-1];
        dvs_neg = is_signed & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        dvd_d       = dvd_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        early_d     = early_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d   = '0;
                    quo_d   = dvd_mag;
                    dvs_d   = dvs_mag;
                    dvd_d   = dividend;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    cnt_d   = CNT_W'(WIDTH);
                    dz_d    = (divisor == '0);
                    early_d = 1'b0;
`ifdef SEQ_DIV_EARLY_TERM_EN
                    early_d = (divisor != '0) && (dvs_mag > dvd_mag);
`endif
                    state_d = (dz_d || early_d) ? FIX : ITER;
                end
            end
            ITER: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    quotient_d  = {WIDTH{DIV_ZERO_QUO[0]}};
                    remainder_d = dvd_q;
                    dbz_d       = 1'b1;
                end else if (early_q) begin
                    quotient_d  = '0;
                    remainder_d = dvd_q;
                    dbz_d       = 1'b0;
                end else begin
                    quotient_d  = q_neg_q ? -quo_q : quo_q;
                    remainder_d = r_neg_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            early_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            dvd_q       <= dvd_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            early_q     <= early_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == ITER) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
